bus_initiator: RTL
==================

Name: bus_initiator

Overview:
- Bus master for the shared system bus used by all memory-mapped devices (PLIC, timers, UART, RAM).
- Accepts one load/store request at a time from the core-side request port.
- Drives addr_bus, data_bus, rd_bus, wr_bus and data_mask_bus, waits for fc_bus from the addressed responder, and returns read data or completion.
- Detects misaligned accesses and responder timeouts and reports them as errors.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent in a strobe state without fc_bus before the access is aborted with an error (must be >= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  core requests an access; sampled only in IDLE
- req_ready  output  1  high in IDLE; the request is accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, low-justified
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
- req_signed  input  1  sign-extend load result when 1
- resp_valid  output  1  one-cycle pulse when the access finishes
- resp_rdata  output  32  extended load data; 0 for stores and errors; held until the next resp_valid
- resp_err  output  1  qualified by resp_valid: misaligned, illegal size, or timeout
- addr_bus  output  32  bus address
- data_bus  inout  32  low-justified bus data
- rd_bus  output  1  read strobe
- wr_bus  output  1  write strobe
- data_mask_bus  output  4  byte-lane mask, low-justified
- fc_bus  input  1  function complete from the responder; pulled low at top level when undriven

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - addr_bus=0, rd_bus=0, wr_bus=0, data_mask_bus=0, data_bus=Z.
  - resp_valid=0, resp_err=0, resp_rdata=0, timeout counter=0.
  - Reset asserted mid-access drops the strobes immediately and produces no response.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, wdata, size, signed and write.
  - Misaligned or illegal request (size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3): no bus cycle. Go to RESP with err=1.
  - Otherwise go to READ or WRITE.
- Mask encoding: size 0 = 4'b0001, size 1 = 4'b0011, size 2 = 4'b1111.
- READ:
  - rd_bus=1; addr_bus and data_mask_bus from the latched request.
  - When fc_bus=1: capture data_bus, extend per size/signed (zero-extend when signed=0), drop rd_bus and go to RELEASE.
  - Read data is sampled on the same edge fc_bus is seen, because the responder drives data combinationally while rd_bus is held.
- WRITE:
  - wr_bus=1; data_bus driven with the latched wdata, low-justified, with the unused upper bytes zeroed.
  - data_bus is driven only in this state.
  - When fc_bus=1, drop wr_bus and go to RELEASE.
  - Responders assert fc_bus on writes no earlier than the cycle after the strobe is seen, so minimum write latency is 2 strobe cycles.
- Timeout:
  - The counter increments each cycle spent in READ or WRITE and clears on leaving those states.
  - When it reaches TIMEOUT_CYCLES-1 without fc_bus: drop the strobe, set err=1, rdata=0, go to RELEASE.
  - If fc_bus arrives on the same cycle the counter expires, fc_bus wins and err=0.
- RELEASE:
  - Strobes are low; addr_bus and mask are held stable.
  - Stay until fc_bus=0, with a minimum of 1 cycle.
  - This lets a responder clear its internal handshake state and perform read side effects (e.g. claim-clear on a PLIC claim read) before the next access.
  - Then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err and resp_rdata are valid that cycle.
  - addr_bus and mask return to 0.
  - Next state is IDLE. A new request can be accepted the following cycle, so there is no back-to-back overlap.
- Only one of rd_bus or wr_bus is ever high; addr_bus never changes while a strobe is high.
- Total latency, accept to resp_valid, with a combinational-fc read responder: 4 cycles (READ, RELEASE, RESP plus the accept edge).

Test Plan:
- Word read from a stub responder returning 32'hDEADBEEF with combinational fc -> rd_bus high 1 cycle; resp_rdata=32'hDEADBEEF, err=0, resp_valid pulse 4 cycles after accept.
- Byte load, addr=0x1003, signed=1, bus data 0x00000080 -> data_mask_bus=4'b0001, resp_rdata=32'hFFFFFF80; repeat with signed=0 -> 32'h00000080.
- Halfword store 0xABCD1234 to 0x2002 with registered-fc stub -> data_bus=32'h00001234, mask=4'b0011, wr_bus high exactly until fc, data_bus Z afterward; resp_err=0.
- Halfword at 0x2001, and size=3 -> no rd_bus/wr_bus pulse; resp_valid with resp_err=1 two cycles after accept.
- Unmapped address (fc never rises), TIMEOUT_CYCLES=16 -> strobe high 16 cycles, then dropped; resp_err=1, resp_rdata=0.
- Assert rst low during WRITE -> wr_bus, data_bus release asynchronously; no resp_valid; next request completes normally.

Source files
------------

// File: rtl/bus_initiator.sv
// Single-outstanding bus master for the shared memory-mapped system bus.
// Accepts one load/store from the core, strobes the bus until the responder
// raises fc_bus (or a timeout expires), waits for fc_bus to fall, then
// returns a one-cycle response carrying extended read data or an error.
module bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RELEASE,
    RESP
  } state_t;

  state_t      state, state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [CW-1:0] tmo_cnt;

  logic        req_bad;
  logic        accept;
  logic        expired;
  logic        drive_data;
  logic [3:0]  mask_q;
  logic [31:0] wdata_trim;
  logic [31:0] rd_ext;

  assign accept  = (state == IDLE) && req_valid;
  assign expired = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Data is driven onto the shared bus only while the write strobe is up.
  assign data_bus = drive_data ? wdata_q : 'z;

  // Alignment / legality check of the incoming request.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = req_addr[0];
      2'd2:    req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Store data trimmed to the access width so unused upper lanes read as zero.
  always_comb begin
    wdata_trim = req_wdata;
    case (req_size)
      2'd0:    wdata_trim = {24'd0, req_wdata[7:0]};
      2'd1:    wdata_trim = {16'd0, req_wdata[15:0]};
      default: wdata_trim = req_wdata;
    endcase
  end

  // Byte-lane mask from the latched access size.
  always_comb begin
    mask_q = '0;
    case (size_q)
      2'd0:    mask_q = 4'b0001;
      2'd1:    mask_q = 4'b0011;
      2'd2:    mask_q = 4'b1111;
      default: mask_q = '0;
    endcase
  end

  // Load data extension according to the latched size and signedness.
  always_comb begin
    rd_ext = data_bus;
    case (size_q)
      2'd0:    rd_ext = {{24{signed_q & data_bus[7]}}, data_bus[7:0]};
      2'd1:    rd_ext = {{16{signed_q & data_bus[15]}}, data_bus[15:0]};
      default: rd_ext = data_bus;
    endcase
  end

  // State register; async reset drops strobes immediately via the decode below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and bus/handshake outputs decoded from the current state.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    rd_bus        = 1'b0;
    wr_bus        = 1'b0;
    addr_bus      = '0;
    data_mask_bus = '0;
    drive_data    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)        state_next = RESP;
          else if (req_write) state_next = WRITE;
          else                state_next = READ;
        end
      end
      READ: begin
        rd_bus        = 1'b1;
        addr_bus      = addr_q;
        data_mask_bus = mask_q;
        if (fc_bus || expired) state_next = RELEASE;
      end
      WRITE: begin
        wr_bus        = 1'b1;
        addr_bus      = addr_q;
        data_mask_bus = mask_q;
        drive_data    = 1'b1;
        if (fc_bus || expired) state_next = RELEASE;
      end
      RELEASE: begin
        addr_bus      = addr_q;
        data_mask_bus = mask_q;
        if (!fc_bus) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Timeout counter: runs while a strobe is held, clears when the strobe ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if ((state == READ || state == WRITE) && state_next == state) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Request latch and access result capture; fc_bus takes priority over expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= wdata_trim;
        size_q   <= req_size;
        signed_q <= req_signed;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end
      if (state == READ || state == WRITE) begin
        if (fc_bus) begin
          rdata_q <= (state == READ) ? rd_ext : '0;
          err_q   <= 1'b0;
        end else if (expired) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Response registers: pulse on entry to RESP, payload held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= (state_next == RESP);
      if (accept && req_bad) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (state == RELEASE && !fc_bus) begin
        resp_err   <= err_q;
        resp_rdata <= rdata_q;
      end
    end
  end

endmodule
